// File: rtl/differentiator.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// differentiator
//   Discrete-time differentiator. Takes sfix22_En20 samples and produces the
//   saturated, GAIN-scaled backward difference in sfix22_En10. An optional
//   first-order low-pass (alpha = 2^-ALPHA_SHIFT) smooths the output.
//   Three pipeline stages, one output per accepted input, no back-pressure.
//
// Ports
//   clk        system clock, rising edge
//   reset      asynchronous, active-low reset
//   clear      synchronous flush back to the EMPTY state
//   in_valid   In carries a sample this cycle
//   In         signed sample, sfix22_En20
//   out_valid  one-cycle pulse, Out updated this cycle
//   Out        signed derivative, sfix22_En10, held between pulses
// -----------------------------------------------------------------------------
module differentiator #(
  parameter int unsigned GAIN        = 1024,
  parameter int unsigned ALPHA_SHIFT = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               in_valid,
  input  logic signed [21:0] In,
  output logic               out_valid,
  output logic signed [21:0] Out
);

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  localparam logic signed [35:0] GAIN_W = 36'(GAIN);

  // Clamp a wide signed value into the 22-bit signed range.
  function automatic logic signed [21:0] sat22(input logic signed [35:0] v);
    logic signed [21:0] r;
    if (v > 36'sd2097151) begin
      r = 22'sh1FFFFF;
    end else if (v < -36'sd2097152) begin
      r = 22'sh200000;
    end else begin
      r = v[21:0];
    end
    return r;
  endfunction

  state_t             state_r;
  logic signed [21:0] x_prev_r;
  logic signed [22:0] diff_r;
  logic signed [21:0] d_r;
  logic signed [21:0] y_r;
  logic               v1_r;
  logic               v2_r;
  logic               v3_r;

  logic               accept_s;
  logic signed [22:0] diff_s;
  logic signed [35:0] prod_s;
  logic signed [35:0] scaled_s;
  logic signed [21:0] d_next_s;
  logic signed [22:0] e_s;
  logic signed [22:0] e_sh_s;
  logic signed [21:0] y_next_s;

  // Input acceptance and backward difference; the very first sample after
  // EMPTY has no predecessor, so it contributes a zero difference.
  always_comb begin
    accept_s = in_valid & ~clear;
    diff_s   = 23'sd0;
    if (state_r == ST_RUN) begin
      diff_s = {In[21], In} - {x_prev_r[21], x_prev_r};
    end else begin
      diff_s = 23'sd0;
    end
  end

  // Scaling: En20 * GAIN, floor-shift to En10, clamp to 22 bits.
  // A 23-bit difference times a 12-bit gain fits well inside 36 bits.
  always_comb begin
    prod_s   = $signed({{13{diff_r[22]}}, diff_r}) * GAIN_W;
    scaled_s = prod_s >>> 10;
    d_next_s = sat22(scaled_s);
  end

  // Smoothing: y moves a 2^-ALPHA_SHIFT fraction of the way toward d.
  always_comb begin
    e_s      = {d_r[21], d_r} - {y_r[21], y_r};
    e_sh_s   = e_s >>> ALPHA_SHIFT;
    y_next_s = d_r;
    if (ALPHA_SHIFT == 32'd0) begin
      y_next_s = d_r;
    end else begin
      y_next_s = sat22($signed({{14{y_r[21]}}, y_r}) + $signed({{13{e_sh_s[22]}}, e_sh_s}));
    end
  end

  // FSM, sample history and the three pipeline stages.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r  <= ST_EMPTY;
      x_prev_r <= 22'sd0;
      diff_r   <= 23'sd0;
      d_r      <= 22'sd0;
      y_r      <= 22'sd0;
      v1_r     <= 1'b0;
      v2_r     <= 1'b0;
      v3_r     <= 1'b0;
    end else if (clear) begin
      state_r  <= ST_EMPTY;
      x_prev_r <= 22'sd0;
      diff_r   <= 23'sd0;
      d_r      <= 22'sd0;
      y_r      <= 22'sd0;
      v1_r     <= 1'b0;
      v2_r     <= 1'b0;
      v3_r     <= 1'b0;
    end else begin
      v1_r <= accept_s;
      v2_r <= v1_r;
      v3_r <= v2_r;
      if (accept_s) begin
        x_prev_r <= In;
        diff_r   <= diff_s;
        state_r  <= ST_RUN;
      end else begin
        x_prev_r <= x_prev_r;
        diff_r   <= diff_r;
        state_r  <= state_r;
      end
      if (v1_r) begin
        d_r <= d_next_s;
      end else begin
        d_r <= d_r;
      end
      if (v2_r) begin
        y_r <= y_next_s;
      end else begin
        y_r <= y_r;
      end
    end
  end

  assign Out       = y_r;
  assign out_valid = v3_r;

endmodule
